// File: rtl/led_pattern_engine.sv
// LED pattern generator: a prescaled step tick drives OFF / BOUNCE / BLINK / FILL
// patterns onto a registered LED bus, with step and pattern-wrap pulses.
module led_pattern_engine #(
    parameter int WIDTH      = 16,
    parameter int TICK_DIV   = 20000000,
    parameter int BOUNCE_TOP = WIDTH - 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             wrap
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] TOP_BIT    = ONE << BOUNCE_TOP;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic [PW-1:0]    presc;
    logic [2:0]       scaler;
    logic [1:0]       mode_q;
    logic [1:0]       speed_q;
    dir_t             dir;

    logic             change;
    logic             presc_wrap;
    logic [2:0]       scaler_next;
    logic [2:0]       speed_mask;
    logic             tick;
    logic [WIDTH-1:0] shift_up;
    logic [WIDTH-1:0] shift_dn;
    logic [WIDTH-1:0] fill_next;

    // The tick tests the scaler value the wrap is about to store, so a speed-s
    // period spans exactly 2^s prescaler wraps counted from a clear.
    always_comb begin
        change      = (mode != mode_q) || (speed != speed_q);
        presc_wrap  = (presc == PRESC_LAST);
        scaler_next = scaler + 3'd1;
        speed_mask  = 3'b000;
        case (speed_q)
            2'd0:    speed_mask = 3'b000;
            2'd1:    speed_mask = 3'b001;
            2'd2:    speed_mask = 3'b011;
            default: speed_mask = 3'b111;
        endcase
        tick      = presc_wrap && ((scaler_next & speed_mask) == 3'b000);
        shift_up  = {led[WIDTH-2:0], 1'b0};
        shift_dn  = {1'b0, led[WIDTH-1:1]};
        fill_next = {led[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            scaler  <= '0;
            mode_q  <= 2'd0;
            speed_q <= 2'd0;
            dir     <= DIR_UP;
            led     <= '0;
            step    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            mode_q  <= mode;
            speed_q <= speed;
            step    <= 1'b0;
            wrap    <= 1'b0;
            if (change) begin
                presc  <= '0;
                scaler <= '0;
                led    <= '0;
                dir    <= DIR_UP;
            end else begin
                if (presc_wrap) begin
                    presc  <= '0;
                    scaler <= scaler_next;
                end else begin
                    presc <= presc + PW'(1);
                end
                if (tick) begin
                    step <= 1'b1;
                    case (mode_q)
                        MODE_OFF: led <= '0;
                        MODE_BOUNCE: begin
                            if (led == '0) begin
                                led <= ONE;
                                dir <= DIR_UP;
                            end else if (dir == DIR_UP) begin
                                led <= shift_up;
                                if (shift_up == TOP_BIT) dir <= DIR_DOWN;
                            end else begin
                                led <= shift_dn;
                                if (shift_dn == ONE) begin
                                    dir  <= DIR_UP;
                                    wrap <= 1'b1;
                                end
                            end
                        end
                        MODE_BLINK: begin
                            if (led == '0) begin
                                led <= ALL_ONES;
                            end else begin
                                led  <= '0;
                                wrap <= 1'b1;
                            end
                        end
                        MODE_FILL: begin
                            if (led == ALL_ONES) begin
                                led  <= '0;
                                wrap <= 1'b1;
                            end else begin
                                led <= fill_next;
                            end
                        end
                        default: led <= '0;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: two instances (8-bit and 2-bit) checked each cycle
// against a step-index model, plus directed literal sequences.
module tb_led_pattern_engine;
    localparam int W8 = 8;
    localparam int TD8 = 4;
    localparam int TOP8 = 4;
    localparam int W2 = 2;
    localparam int TD2 = 2;
    localparam int TOP2 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode8, speed8, mode2, speed2;
    logic [7:0] led8;
    logic       step8, wrap8;
    logic [1:0] led2;
    logic       step2, wrap2;

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    led_pattern_engine #(.WIDTH(W8), .TICK_DIV(TD8), .BOUNCE_TOP(TOP8)) dut8 (
        .clk(clk), .rst(rst), .mode(mode8), .speed(speed8),
        .led(led8), .step(step8), .wrap(wrap8)
    );

    led_pattern_engine #(.WIDTH(W2), .TICK_DIV(TD2), .BOUNCE_TOP(TOP2)) dut2 (
        .clk(clk), .rst(rst), .mode(mode2), .speed(speed2),
        .led(led2), .step(step2), .wrap(wrap2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pattern value after the k-th step (k >= 1) since the last clear.
    function automatic logic [31:0] pat_led(input int m, input int k, input int w, input int top);
        int p;
        int pos;
        longint ones;
        ones = (longint'(1) << w) - 1;
        case (m)
            1: begin
                p = (k - 1) % (2 * top);
                pos = (p <= top) ? p : 2 * top - p;
                return 32'(longint'(1) << pos);
            end
            2: return (k % 2 == 1) ? 32'(ones) : 32'd0;
            3: begin
                p = (k - 1) % (w + 1);
                return (p < w) ? 32'((longint'(1) << (p + 1)) - 1) : 32'd0;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic pat_wrap(input int m, input int k, input int w, input int top);
        case (m)
            1: return (k > 1) && ((k - 1) % (2 * top) == 0);
            2: return (k % 2 == 0);
            3: return ((k - 1) % (w + 1) == w);
            default: return 1'b0;
        endcase
    endfunction

    // Model: count cycles since the last clear; a step lands on every multiple of the period.
    logic [1:0]  m8_mq, m8_sq, m2_mq, m2_sq;
    int          m8_cyc, m8_k, m2_cyc, m2_k;
    logic [31:0] e8_led, e2_led;
    logic        e8_step, e8_wrap, e2_step, e2_wrap;

    always @(posedge clk) begin
        if (rst) begin
            m8_mq <= 2'd0; m8_sq <= 2'd0; m8_cyc <= 0; m8_k <= 0;
            e8_led <= 32'd0; e8_step <= 1'b0; e8_wrap <= 1'b0;
        end else if (mode8 != m8_mq || speed8 != m8_sq) begin
            m8_mq <= mode8; m8_sq <= speed8; m8_cyc <= 0; m8_k <= 0;
            e8_led <= 32'd0; e8_step <= 1'b0; e8_wrap <= 1'b0;
        end else begin
            m8_cyc <= m8_cyc + 1;
            if ((m8_cyc + 1) % (TD8 << int'(m8_sq)) == 0) begin
                m8_k    <= m8_k + 1;
                e8_led  <= pat_led(int'(m8_mq), m8_k + 1, W8, TOP8);
                e8_step <= 1'b1;
                e8_wrap <= pat_wrap(int'(m8_mq), m8_k + 1, W8, TOP8);
            end else begin
                e8_step <= 1'b0;
                e8_wrap <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m2_mq <= 2'd0; m2_sq <= 2'd0; m2_cyc <= 0; m2_k <= 0;
            e2_led <= 32'd0; e2_step <= 1'b0; e2_wrap <= 1'b0;
        end else if (mode2 != m2_mq || speed2 != m2_sq) begin
            m2_mq <= mode2; m2_sq <= speed2; m2_cyc <= 0; m2_k <= 0;
            e2_led <= 32'd0; e2_step <= 1'b0; e2_wrap <= 1'b0;
        end else begin
            m2_cyc <= m2_cyc + 1;
            if ((m2_cyc + 1) % (TD2 << int'(m2_sq)) == 0) begin
                m2_k    <= m2_k + 1;
                e2_led  <= pat_led(int'(m2_mq), m2_k + 1, W2, TOP2);
                e2_step <= 1'b1;
                e2_wrap <= pat_wrap(int'(m2_mq), m2_k + 1, W2, TOP2);
            end else begin
                e2_step <= 1'b0;
                e2_wrap <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model8_led", {24'd0, led8}, e8_led);
            check("model8_step", {31'd0, step8}, {31'd0, e8_step});
            check("model8_wrap", {31'd0, wrap8}, {31'd0, e8_wrap});
            check("model2_led", {30'd0, led2}, e2_led);
            check("model2_step", {31'd0, step2}, {31'd0, e2_step});
            check("model2_wrap", {31'd0, wrap2}, {31'd0, e2_wrap});
        end
    end

    task automatic wait_step(input int sel, output logic [7:0] l, output logic w, output int gap);
        logic s;
        s = 1'b0;
        gap = 0;
        while (!s && gap < 100) begin
            @(negedge clk);
            gap++;
            s = (sel != 0) ? step2 : step8;
        end
        if (!s) begin
            checks++;
            failures++;
            $display("FAIL step_timeout dut=%0d waited=%0d cycles", sel, gap);
        end
        l = (sel != 0) ? {6'd0, led2} : led8;
        w = (sel != 0) ? wrap2 : wrap8;
    endtask

    task automatic run_seq(input int sel, input string name, input int n,
                           input logic [7:0] exp_l [0:9], input logic exp_w [0:9],
                           input int first_gap, input int gap_n);
        logic [7:0] l;
        logic w;
        int gap;
        for (int i = 0; i < n; i++) begin
            wait_step(sel, l, w, gap);
            check({name, "_led"}, {24'd0, l}, {24'd0, exp_l[i]});
            check({name, "_wrap"}, {31'd0, w}, {31'd0, exp_w[i]});
            check({name, "_gap"}, gap, (i == 0) ? first_gap : gap_n);
        end
    endtask

    logic [7:0] seq_l [0:9];
    logic       seq_w [0:9];
    logic [7:0] l;
    logic       w;
    int         gap;

    initial begin
        rst = 1'b1;
        mode8 = 2'd0; speed8 = 2'd0; mode2 = 2'd0; speed2 = 2'd0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_led8", {24'd0, led8}, 32'h0);
        check("reset_step8", {31'd0, step8}, 32'h0);
        check("reset_wrap8", {31'd0, wrap8}, 32'h0);
        check("reset_led2", {30'd0, led2}, 32'h0);

        // BOUNCE from reset release: first step one change edge plus a period away.
        rst = 1'b0;
        mode8 = 2'd1;
        seq_l = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        seq_w = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        run_seq(0, "bounce8", 10, seq_l, seq_w, 5, 4);
        seq_l = '{8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        seq_w = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_seq(0, "bounce8_b", 2, seq_l, seq_w, 4, 4);

        // Switch to FILL on the edge that would also be a tick.
        repeat (3) @(negedge clk);
        mode8 = 2'd3;
        @(negedge clk);
        check("switch_led", {24'd0, led8}, 32'h0);
        check("switch_step", {31'd0, step8}, 32'h0);
        check("switch_wrap", {31'd0, wrap8}, 32'h0);
        seq_l = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};
        seq_w = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        run_seq(0, "fill8", 10, seq_l, seq_w, 4, 4);
        seq_l = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        seq_w = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_seq(0, "fill8_b", 5, seq_l, seq_w, 4, 4);

        // One-cycle reset while led=3F.
        rst = 1'b1;
        @(negedge clk);
        check("midrst_led", {24'd0, led8}, 32'h0);
        check("midrst_step", {31'd0, step8}, 32'h0);
        check("midrst_wrap", {31'd0, wrap8}, 32'h0);
        rst = 1'b0;
        wait_step(0, l, w, gap);
        check("midrst_first_led", {24'd0, l}, 32'h01);
        check("midrst_first_gap", gap, 5);

        // BLINK at speed 2: 16-cycle step period.
        mode8 = 2'd2; speed8 = 2'd2;
        seq_l = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        seq_w = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        run_seq(0, "blink8", 4, seq_l, seq_w, 17, 16);

        // OFF still steps, never lights or wraps.
        mode8 = 2'd0; speed8 = 2'd1;
        seq_l = '{default: 8'h00};
        seq_w = '{default: 1'b0};
        run_seq(0, "off8", 3, seq_l, seq_w, 9, 8);

        // Narrow instance: BOUNCE then FILL.
        mode2 = 2'd1;
        seq_l = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        seq_w = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        run_seq(1, "bounce2", 5, seq_l, seq_w, 3, 2);
        mode2 = 2'd3;
        seq_l = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        seq_w = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
        run_seq(1, "fill2", 6, seq_l, seq_w, 3, 2);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
